// File: rtl/dmx_rx.sv
// DMX512 receiver: decodes frames from the raw line and packs slot pairs into
// 16-bit words written through a strobed SRAM write port.
module dmx_rx #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16,
  parameter int CLOCKS_PER_BIT    = 192,
  parameter int BREAK_MIN_CLOCKS  = 4224,
  parameter int MAX_SLOTS         = 512
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dmx_in,
  input  logic [ADDRESS_BUS_WIDTH-1:0] base_address,
  output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  output logic [DATA_BUS_WIDTH-1:0]    write_data,
  output logic                         write_strobe,
  output logic                         frame_strobe,
  output logic [9:0]                   slot_count,
  output logic                         framing_error
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam int LW = $clog2(BREAK_MIN_CLOCKS + 1);
  localparam logic [TW-1:0] HALF_BIT  = TW'(CLOCKS_PER_BIT / 2);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [LW-1:0] BREAK_MAX = LW'(BREAK_MIN_CLOCKS);
  localparam logic [LW-1:0] BREAK_PRE = LW'(BREAK_MIN_CLOCKS - 1);
  localparam logic [9:0]    MAX_CNT   = 10'(MAX_SLOTS);

  // Write-port handshake: write_strobe is a single-cycle valid with no ready;
  // write_address/write_data are only meaningful while it is high. The
  // consumer must accept every pulse.

  typedef enum logic [2:0] {
    WAIT_IDLE, BREAK, MAB, START_BIT, DATA_BITS, STOP_BIT, STOP_LOW, IDLE_HIGH
  } state_t;

  state_t state_q, state_d;

  logic                         sync1_q, sync1_d;
  logic                         s_q, s_d;
  logic                         s_prev_q, s_prev_d;
  logic [LW-1:0]                low_cnt_q, low_cnt_d;
  logic [TW-1:0]                timer_q, timer_d;
  logic [2:0]                   bit_idx_q, bit_idx_d;
  logic [7:0]                   shift_q, shift_d;
  logic                         start_seen_q, start_seen_d;
  logic                         frame_active_q, frame_active_d;
  logic [9:0]                   data_cnt_q, data_cnt_d;
  logic [7:0]                   pending_q, pending_d;
  logic [ADDRESS_BUS_WIDTH-1:0] base_q, base_d;
  logic                         eof_pend_q, eof_pend_d;
  logic [9:0]                   eof_count_q, eof_count_d;
  logic                         wr_strobe_q, wr_strobe_d;
  logic [ADDRESS_BUS_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_BUS_WIDTH-1:0]    wr_data_q, wr_data_d;
  logic                         fr_strobe_q, fr_strobe_d;
  logic [9:0]                   slot_cnt_q, slot_cnt_d;
  logic                         ferr_q, ferr_d;

  logic       fall;
  logic       break_hit;
  logic       byte_valid;
  logic [9:0] slot_n;

  assign write_address = wr_addr_q;
  assign write_data    = wr_data_q;
  assign write_strobe  = wr_strobe_q;
  assign frame_strobe  = fr_strobe_q;
  assign slot_count    = slot_cnt_q;
  assign framing_error = ferr_q;

  assign fall      = s_prev_q & ~s_q;
  // Fires once, on the cycle the low run reaches the break length.
  assign break_hit = ~s_q && (low_cnt_q == BREAK_PRE);
  assign slot_n    = data_cnt_q + 10'd1;

  // Synchroniser and saturating low-run counter, independent of the FSM.
  always_comb begin
    sync1_d   = dmx_in;
    s_d       = sync1_q;
    s_prev_d  = s_q;
    low_cnt_d = '0;
    if (!s_q) low_cnt_d = (low_cnt_q == BREAK_MAX) ? BREAK_MAX : low_cnt_q + 1'b1;
  end

  // Frame FSM, slot packing and output pulse generation.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    bit_idx_d      = bit_idx_q;
    shift_d        = shift_q;
    start_seen_d   = start_seen_q;
    frame_active_d = frame_active_q;
    data_cnt_d     = data_cnt_q;
    pending_d      = pending_q;
    base_d         = base_q;
    eof_pend_d     = 1'b0;
    eof_count_d    = eof_count_q;
    wr_strobe_d    = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    fr_strobe_d    = 1'b0;
    slot_cnt_d     = slot_cnt_q;
    ferr_d         = 1'b0;
    byte_valid     = 1'b0;

    // A flush or final-slot write was issued last cycle; close the frame now.
    if (eof_pend_q) begin
      fr_strobe_d = 1'b1;
      slot_cnt_d  = eof_count_q;
    end

    if (break_hit) begin
      state_d = BREAK;
      if (frame_active_q) begin
        if (data_cnt_q[0]) begin
          wr_strobe_d = 1'b1;
          wr_addr_d   = base_q + ADDRESS_BUS_WIDTH'(data_cnt_q >> 1);
          wr_data_d   = DATA_BUS_WIDTH'({pending_q, 8'h00});
          eof_pend_d  = 1'b1;
          eof_count_d = data_cnt_q;
        end else begin
          fr_strobe_d = 1'b1;
          slot_cnt_d  = data_cnt_q;
        end
      end
      frame_active_d = 1'b0;
      start_seen_d   = 1'b0;
      data_cnt_d     = '0;
      base_d         = base_address;
    end else begin
      case (state_q)
        WAIT_IDLE: ;
        BREAK: if (s_q) state_d = MAB;
        MAB: begin
          timer_d = '0;
          if (fall) state_d = START_BIT;
        end
        START_BIT: begin
          if (timer_q == HALF_BIT) begin
            if (s_q) begin
              state_d = IDLE_HIGH;
            end else begin
              state_d   = DATA_BITS;
              timer_d   = '0;
              bit_idx_d = '0;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        DATA_BITS: begin
          if (timer_q == LAST_TICK) begin
            timer_d   = '0;
            shift_d   = {s_q, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 1'b1;
            if (bit_idx_q == 3'd7) state_d = STOP_BIT;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        STOP_BIT: begin
          if (timer_q == LAST_TICK) begin
            timer_d = '0;
            if (s_q) begin
              byte_valid = 1'b1;
              state_d    = IDLE_HIGH;
            end else begin
              state_d = STOP_LOW;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        STOP_LOW: begin
          if (s_q) begin
            ferr_d  = 1'b1;
            state_d = IDLE_HIGH;
          end
        end
        IDLE_HIGH: begin
          timer_d = '0;
          if (fall) state_d = START_BIT;
        end
        default: state_d = WAIT_IDLE;
      endcase
    end

    // Slot bookkeeping for a byte that passed its stop bit.
    if (byte_valid) begin
      if (!start_seen_q) begin
        start_seen_d   = 1'b1;
        frame_active_d = (shift_q == 8'h00);
      end else if (frame_active_q && (data_cnt_q < MAX_CNT)) begin
        data_cnt_d = slot_n;
        wr_addr_d  = base_q + ADDRESS_BUS_WIDTH'(data_cnt_q >> 1);
        if (!slot_n[0]) begin
          wr_strobe_d = 1'b1;
          wr_data_d   = DATA_BUS_WIDTH'({pending_q, shift_q});
        end else if (slot_n == MAX_CNT) begin
          wr_strobe_d = 1'b1;
          wr_data_d   = DATA_BUS_WIDTH'({shift_q, 8'h00});
        end else begin
          pending_d = shift_q;
        end
        if (slot_n == MAX_CNT) begin
          eof_pend_d     = 1'b1;
          eof_count_d    = slot_n;
          frame_active_d = 1'b0;
        end
      end
    end
  end

  // Synchroniser flops reset high so reset does not look like a falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      s_q       <= 1'b1;
      s_prev_q  <= 1'b1;
      low_cnt_q <= '0;
    end else begin
      sync1_q   <= sync1_d;
      s_q       <= s_d;
      s_prev_q  <= s_prev_d;
      low_cnt_q <= low_cnt_d;
    end
  end

  // FSM state, frame context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= WAIT_IDLE;
      timer_q        <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      start_seen_q   <= 1'b0;
      frame_active_q <= 1'b0;
      data_cnt_q     <= '0;
      pending_q      <= '0;
      base_q         <= '0;
      eof_pend_q     <= 1'b0;
      eof_count_q    <= '0;
      wr_strobe_q    <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      fr_strobe_q    <= 1'b0;
      slot_cnt_q     <= '0;
      ferr_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      bit_idx_q      <= bit_idx_d;
      shift_q        <= shift_d;
      start_seen_q   <= start_seen_d;
      frame_active_q <= frame_active_d;
      data_cnt_q     <= data_cnt_d;
      pending_q      <= pending_d;
      base_q         <= base_d;
      eof_pend_q     <= eof_pend_d;
      eof_count_q    <= eof_count_d;
      wr_strobe_q    <= wr_strobe_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      fr_strobe_q    <= fr_strobe_d;
      slot_cnt_q     <= slot_cnt_d;
      ferr_q         <= ferr_d;
    end
  end

endmodule

// File: tb/tb_dmx_rx.sv
// Bench for dmx_rx: frame table with random slot data, a frame-level model of
// the expected SRAM writes, and hand sequences for framing/break/reset cases.
module tb_dmx_rx;

  localparam int CPB   = 8;
  localparam int BRK   = 100;
  localparam int BRK_T = 120;
  localparam int MAB_T = 24;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dmx_in = 1'b1;
  logic [15:0] base_address = 16'h0000;
  logic [15:0] write_address;
  logic [15:0] write_data;
  logic        write_strobe;
  logic        frame_strobe;
  logic [9:0]  slot_count;
  logic        framing_error;

  dmx_rx #(
    .ADDRESS_BUS_WIDTH(16),
    .DATA_BUS_WIDTH(16),
    .CLOCKS_PER_BIT(CPB),
    .BREAK_MIN_CLOCKS(BRK),
    .MAX_SLOTS(512)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dmx_in(dmx_in),
    .base_address(base_address),
    .write_address(write_address),
    .write_data(write_data),
    .write_strobe(write_strobe),
    .frame_strobe(frame_strobe),
    .slot_count(slot_count),
    .framing_error(framing_error)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];        // {address, data}
  logic [10:0] exp_frame_q[$];  // {frame_strobe directly follows a write, slot_count}
  logic [7:0]  bytes [0:600];
  int n_cmp = 0;
  int n_fail = 0;
  int wr_seen = 0;
  int fe_seen = 0;
  int exp_writes = 0;
  int last_wr_cyc = -10;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every write and frame strobe is matched against the expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (write_strobe) begin
        wr_seen++;
        last_wr_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL write_unexpected: got %h@%h want no write", write_data, write_address);
        end else begin
          check("write_addr_data", {write_address, write_data}, exp_q.pop_front());
        end
      end
      if (frame_strobe) begin
        if (exp_frame_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL frame_unexpected: got slot_count %0d want no frame_strobe", slot_count);
        end else begin
          logic [10:0] f;
          f = exp_frame_q.pop_front();
          check("slot_count", 32'(slot_count), 32'(f[9:0]));
          if (f[10]) check("frame_after_write", 32'(cyc - last_wr_cyc), 32'd1);
        end
      end
      if (framing_error) fe_seen++;
    end
  end

  // ---------------- reference model ----------------
  // Frame-level view: slots 1..c in bytes[], paired two per word from base.
  task automatic model_frame(input logic [15:0] base, input logic [7:0] sc, input int n,
                             input logic exp_frame, input logic [9:0] exp_count);
    int c;
    c = (n > 512) ? 512 : n;
    if (sc == 8'h00) begin
      for (int k = 2; k <= c; k += 2) begin
        exp_q.push_back({base + 16'(k / 2 - 1), bytes[k-1], bytes[k]});
        exp_writes++;
      end
      if (c % 2 == 1) begin
        exp_q.push_back({base + 16'((c - 1) / 2), bytes[c], 8'h00});
        exp_writes++;
      end
    end
    if (exp_frame) exp_frame_q.push_back({(c % 2 == 1) || (c == 512), exp_count});
  endtask

  // ---------------- driver tasks ----------------
  task automatic line(input logic v, input int n);
    dmx_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int stop_low);
    line(1'b0, CPB);
    for (int i = 0; i < 8; i++) line(b[i], CPB);
    if (stop_low > 0) line(1'b0, stop_low);
    line(1'b1, CPB);
  endtask

  task automatic do_break(input int len, input int mab);
    line(1'b0, len);
    line(1'b1, mab);
  endtask

  task automatic send_frame(input logic [7:0] sc, input int n);
    send_byte(sc, 0);
    for (int k = 1; k <= n; k++) begin
      send_byte(bytes[k], 0);
      line(1'b1, $urandom_range(0, 3));
    end
  endtask

  task automatic drain_check(input string name);
    check({name, "_writes"}, 32'(wr_seen), 32'(exp_writes));
    check({name, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_frames_left"}, 32'(exp_frame_q.size()), 32'd0);
  endtask

  // ---------------- frame table ----------------
  typedef struct {
    logic [15:0] base;
    logic [7:0]  sc;
    int          n;
    int          mode;      // 0: k*0x11, 1: k[7:0], 2: random, 3: 0xAA + 0x11*(k-1)
    logic        exp_frame;
    logic [9:0]  exp_count;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'h0100, 8'h00, 4,   0, 1'b1, 10'd4};
    vecs[1] = '{16'h0200, 8'h00, 3,   3, 1'b1, 10'd3};
    vecs[2] = '{16'h0300, 8'h17, 10,  2, 1'b0, 10'd0};
    vecs[3] = '{16'hFF00, 8'h00, 513, 1, 1'b1, 10'd512};
    vecs[4] = '{16'h0400, 8'h00, 0,   2, 1'b1, 10'd0};
    vecs[5] = '{16'hFFFF, 8'h00, 5,   2, 1'b1, 10'd5};
    for (int i = 6; i < 9; i++) begin
      int n;
      n = $urandom_range(1, 20);
      vecs[i] = '{16'($urandom), 8'h00, n, 2, 1'b1, 10'(n)};
    end
    vecs[9] = '{16'($urandom), 8'($urandom_range(1, 255)), 6, 2, 1'b0, 10'd0};

    // reset state
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_write_address", 32'(write_address), 32'd0);
    check("rst_write_data", 32'(write_data), 32'd0);
    check("rst_write_strobe", 32'(write_strobe), 32'd0);
    check("rst_frame_strobe", 32'(frame_strobe), 32'd0);
    check("rst_slot_count", 32'(slot_count), 32'd0);
    check("rst_framing_error", 32'(framing_error), 32'd0);
    rst = 1'b0;
    line(1'b1, 20);

    // table-driven frames; each break closes the previous frame
    for (int i = 0; i < 10; i++) begin
      base_address = vecs[i].base;
      do_break(BRK_T, MAB_T + $urandom_range(0, 8));
      drain_check("frame");
      for (int k = 1; k <= vecs[i].n; k++) begin
        case (vecs[i].mode)
          0: bytes[k] = 8'(k * 17);
          1: bytes[k] = 8'(k);
          3: bytes[k] = 8'(8'hAA + 17 * (k - 1));
          default: bytes[k] = 8'($urandom);
        endcase
      end
      model_frame(vecs[i].base, vecs[i].sc, vecs[i].n, vecs[i].exp_frame, vecs[i].exp_count);
      send_frame(vecs[i].sc, vecs[i].n);
    end
    base_address = 16'h0600;
    do_break(BRK_T, MAB_T);
    drain_check("table_end");

    // stop bit held low for one bit, then high: one framing error, slot dropped
    bytes[1] = 8'h66;
    bytes[2] = 8'h77;
    model_frame(16'h0600, 8'h00, 2, 1'b1, 10'd2);
    send_byte(8'h00, 0);
    send_byte(8'h5A, CPB);
    line(1'b1, 5);
    send_byte(8'h66, 0);
    send_byte(8'h77, 0);
    base_address = 16'h0700;
    do_break(BRK_T, MAB_T);
    drain_check("stop_low");
    check("framing_error_once", 32'(fe_seen), 32'd1);

    // long low starting in a stop bit is a break: no error, frame flushed
    bytes[1] = 8'h12;
    model_frame(16'h0700, 8'h00, 1, 1'b1, 10'd1);
    send_byte(8'h00, 0);
    send_byte(8'h12, 0);
    send_byte(8'h34, 130);
    line(1'b1, 16);
    drain_check("stop_break");
    check("framing_error_none", 32'(fe_seen), 32'd1);

    // reset mid-frame after slot 3
    base_address = 16'h0800;
    do_break(BRK_T, MAB_T);
    bytes[1] = 8'hA1;
    bytes[2] = 8'hA2;
    model_frame(16'h0800, 8'h00, 2, 1'b0, 10'd0);
    send_byte(8'h00, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 0);
    send_byte(8'hA3, 0);
    line(1'b0, 20);
    rst = 1'b1;
    #2;
    check("midrst_write_address", 32'(write_address), 32'd0);
    check("midrst_write_data", 32'(write_data), 32'd0);
    check("midrst_slot_count", 32'(slot_count), 32'd0);
    dmx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    line(1'b1, 20);
    send_byte(8'h00, 0);
    send_byte(8'hB1, 0);
    send_byte(8'hB2, 0);
    line(1'b1, 10);
    drain_check("after_rst");
    base_address = 16'h0900;
    do_break(BRK_T, MAB_T);
    bytes[1] = 8'hC1;
    bytes[2] = 8'hC2;
    model_frame(16'h0900, 8'h00, 2, 1'b1, 10'd2);
    send_frame(8'h00, 2);
    do_break(BRK_T, MAB_T);
    drain_check("resume");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
